branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
Sequences control-flow resolution for the MIPS core. The block accepts one branch or jump request from decode and builds the word-aligned target (sign-extended offset shifted left by 2, plus PC+4; or a pseudo-direct jump; or a register jump). It decides taken or not-taken, then runs a redirect/ack handshake with the PC register followed by a timed pipeline flush. It sits between the decode stage and the PC-source mux.

Parameters:
FLUSH_CYCLES, 2, number of cycles flush_o stays high after redirect is acknowledged (legal range 1..15)
CNT_W, 16, width of the saturating taken-event counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
br_valid_i  input  1  decode presents a request
br_ready_o  output  1  controller can accept a request
br_type_i  input  3  0 NONE, 1 BEQ, 2 BNE, 3 J, 4 JAL, 5 JR, 6-7 reserved
pc_plus4_i  input  32  PC+4 of the control-flow instruction
imm_i  input  16  branch offset field
jaddr_i  input  26  jump index field
rs_data_i  input  32  rs operand
rt_data_i  input  32  rt operand
redirect_valid_o  output  1  new PC offered to the PC register
redirect_pc_o  output  32  target PC
redirect_ack_i  input  1  PC register has taken the target
flush_o  output  1  squash younger pipeline stages
link_we_o  output  1  one-cycle write of $ra
link_data_o  output  32  link value
align_err_o  output  1  one-cycle pulse: JR target had rs[1:0] != 0
taken_cnt_o  output  CNT_W  saturating count of taken redirects

Behaviour:
- Reset (reset=0, asynchronous) sets state=IDLE. All outputs are 0 except br_ready_o. Counters clear. Reset mid-operation abandons any pending redirect or flush immediately.
- States: IDLE, EVAL, REDIRECT, FLUSH. br_ready_o=1 only in IDLE.
- IDLE: when br_valid_i & br_ready_o, register all request inputs and go to EVAL. Inputs are ignored in other states.
- EVAL (exactly 1 cycle), using the registered operands:
  - BEQ: taken when rs==rt. BNE: taken when rs!=rt. Target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00}, 32-bit wrap-around with no overflow flag.
  - J and JAL: always taken. Target = {pc_plus4[31:28], jaddr, 2'b00}.
  - JAL: link_we_o=1 for this cycle, with link_data_o=pc_plus4.
  - JR: always taken. Target = {rs[31:2], 2'b00}. If rs[1:0]!=0, align_err_o=1 for this cycle.
  - NONE and reserved codes: not taken.
  - Taken goes to REDIRECT. Not taken goes to IDLE with no redirect and no flush.
- REDIRECT: redirect_valid_o=1, and redirect_pc_o holds steady until redirect_ack_i=1 (the ack may arrive in the first REDIRECT cycle). On the ack cycle, increment taken_cnt_o (saturates at all-ones), load the flush counter with FLUSH_CYCLES, and go to FLUSH.
- redirect_ack_i outside REDIRECT is ignored.
- FLUSH: flush_o=1, decrement the counter each cycle, and go to IDLE in the cycle the counter reaches 1. flush_o is high for exactly FLUSH_CYCLES cycles.
- redirect_valid_o and flush_o are never high in the same cycle.
- redirect_pc_o and link_data_o return to 0 outside REDIRECT and EVAL respectively.
- All outputs are registered or decoded directly from state. There is no combinational path from inputs to br_ready_o.
- Minimum taken sequence, with the accept at cycle 0: EVAL at 1, redirect_valid_o at 2, ack at 2, flush_o at 3..(2+FLUSH_CYCLES), br_ready_o back at 3+FLUSH_CYCLES.
- Not-taken request: br_ready_o returns at cycle 2.

Test Plan:
- BEQ with rs=rt=0x5, pc_plus4=0x00400010, imm=0xFFFC, ack held high -> redirect_pc_o=0x00400000 at cycle 2, flush_o high cycles 3-4, taken_cnt_o=1.
- BNE with rs=rt=0x7 -> no redirect_valid_o, no flush_o, br_ready_o=1 at cycle 2, taken_cnt_o unchanged.
- JAL with pc_plus4=0x90000004, jaddr=0x0100000 -> link_we_o pulse with link_data_o=0x90000004, then redirect_pc_o=0x90400000.
- JR with rs=0x00400023, ack delayed 3 cycles -> align_err_o pulse in EVAL; redirect_pc_o=0x00400020 held stable all 3 cycles; br_valid_i pulses during the wait are ignored.
- Assert reset=0 during the second FLUSH cycle -> all outputs 0 and br_ready_o=1 immediately without a clock edge. A new request after reset release processes normally.
- Run 65536 taken branches with CNT_W=16 -> taken_cnt_o saturates at 0xFFFF and does not wrap.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Control-flow resolution between decode and the PC-source mux: evaluates one
// branch/jump, offers the target to the PC register, then holds a timed flush.
module branch_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid_i,
  output logic             br_ready_o,
  input  logic [2:0]       br_type_i,
  input  logic [31:0]      pc_plus4_i,
  input  logic [15:0]      imm_i,
  input  logic [25:0]      jaddr_i,
  input  logic [31:0]      rs_data_i,
  input  logic [31:0]      rt_data_i,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  input  logic             redirect_ack_i,
  output logic             flush_o,
  output logic             link_we_o,
  output logic [31:0]      link_data_o,
  output logic             align_err_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_EVAL     = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;
  localparam logic [1:0] ST_FLUSH    = 2'd3;

  localparam logic [2:0] BT_BEQ = 3'd1;
  localparam logic [2:0] BT_BNE = 3'd2;
  localparam logic [2:0] BT_J   = 3'd3;
  localparam logic [2:0] BT_JAL = 3'd4;
  localparam logic [2:0] BT_JR  = 3'd5;

  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [1:0]       state_r;
  logic [1:0]       next_state_s;
  logic [2:0]       type_r;
  logic [31:0]      pc_plus4_r;
  logic [15:0]      imm_r;
  logic [25:0]      jaddr_r;
  logic [31:0]      rs_r;
  logic [31:0]      rt_r;
  logic [31:0]      target_r;
  logic [31:0]      target_s;
  logic             taken_s;
  logic [3:0]       flush_cnt_r;
  logic [CNT_W-1:0] taken_cnt_r;
  logic             accept_s;
  logic             ack_s;

  // Word-aligned PC-relative target; the add wraps at 32 bits.
  function automatic logic [31:0] rel_target(input logic [31:0] pc, input logic [15:0] imm);
    return pc + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  assign accept_s = (state_r == ST_IDLE) && br_valid_i;
  assign ack_s    = (state_r == ST_REDIRECT) && redirect_ack_i;

  // Taken decision and target selection from the captured request.
  always_comb begin
    taken_s  = 1'b0;
    target_s = 32'd0;
    case (type_r)
      BT_BEQ: begin
        taken_s  = (rs_r == rt_r);
        target_s = rel_target(pc_plus4_r, imm_r);
      end
      BT_BNE: begin
        taken_s  = (rs_r != rt_r);
        target_s = rel_target(pc_plus4_r, imm_r);
      end
      BT_J, BT_JAL: begin
        taken_s  = 1'b1;
        target_s = {pc_plus4_r[31:28], jaddr_r, 2'b00};
      end
      BT_JR: begin
        taken_s  = 1'b1;
        target_s = {rs_r[31:2], 2'b00};
      end
      default: begin
        taken_s  = 1'b0;
        target_s = 32'd0;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (br_valid_i) next_state_s = ST_EVAL;
        else            next_state_s = ST_IDLE;
      end
      ST_EVAL: begin
        if (taken_s) next_state_s = ST_REDIRECT;
        else         next_state_s = ST_IDLE;
      end
      ST_REDIRECT: begin
        if (redirect_ack_i) next_state_s = ST_FLUSH;
        else                next_state_s = ST_REDIRECT;
      end
      ST_FLUSH: begin
        if (flush_cnt_r <= 4'd1) next_state_s = ST_IDLE;
        else                     next_state_s = ST_FLUSH;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // Request capture on accept; held untouched until the next accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      type_r     <= 3'd0;
      pc_plus4_r <= 32'd0;
      imm_r      <= 16'd0;
      jaddr_r    <= 26'd0;
      rs_r       <= 32'd0;
      rt_r       <= 32'd0;
    end else if (accept_s) begin
      type_r     <= br_type_i;
      pc_plus4_r <= pc_plus4_i;
      imm_r      <= imm_i;
      jaddr_r    <= jaddr_i;
      rs_r       <= rs_data_i;
      rt_r       <= rt_data_i;
    end
  end

  // Target is latched in EVAL so redirect_pc_o stays steady while waiting for ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    target_r <= 32'd0;
    else if (state_r == ST_EVAL)   target_r <= target_s;
  end

  // Flush timer: loaded on ack, counts down through FLUSH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                       flush_cnt_r <= 4'd0;
    else if (ack_s)                                   flush_cnt_r <= FLUSH_LOAD;
    else if (state_r == ST_FLUSH && flush_cnt_r != 4'd0) flush_cnt_r <= flush_cnt_r - 4'd1;
  end

  // Saturating count of acknowledged redirects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            taken_cnt_r <= {CNT_W{1'b0}};
    else if (ack_s && taken_cnt_r != CNT_MAX) taken_cnt_r <= taken_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign br_ready_o       = (state_r == ST_IDLE);
  assign redirect_valid_o = (state_r == ST_REDIRECT);
  assign redirect_pc_o    = (state_r == ST_REDIRECT) ? target_r : 32'd0;
  assign flush_o          = (state_r == ST_FLUSH);
  assign link_we_o        = (state_r == ST_EVAL) && (type_r == BT_JAL);
  assign link_data_o      = link_we_o ? pc_plus4_r : 32'd0;
  assign align_err_o      = (state_r == ST_EVAL) && (type_r == BT_JR) && (rs_r[1:0] != 2'b00);
  assign taken_cnt_o      = taken_cnt_r;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Randomized and directed bench for branch_redirect_ctrl against a transaction-level model.
module tb_branch_redirect_ctrl;
  localparam int FL = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        br_valid = 1'b0;
  logic [2:0]  br_type = 3'd0;
  logic [31:0] pc_plus4 = 32'd0;
  logic [15:0] imm = 16'd0;
  logic [25:0] jaddr = 26'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        redirect_ack = 1'b0;

  logic        br_ready, redirect_valid, flush, link_we, align_err;
  logic [31:0] redirect_pc, link_data;
  logic [15:0] taken_cnt;

  logic        s_ready, s_rv, s_flush, s_lwe, s_aerr;
  logic [31:0] s_pc, s_ldata;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int exp_cnt4 = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.FLUSH_CYCLES(FL), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .br_valid_i(br_valid), .br_ready_o(br_ready),
    .br_type_i(br_type), .pc_plus4_i(pc_plus4), .imm_i(imm), .jaddr_i(jaddr),
    .rs_data_i(rs_data), .rt_data_i(rt_data), .redirect_valid_o(redirect_valid),
    .redirect_pc_o(redirect_pc), .redirect_ack_i(redirect_ack), .flush_o(flush),
    .link_we_o(link_we), .link_data_o(link_data), .align_err_o(align_err),
    .taken_cnt_o(taken_cnt));

  // Narrow-counter copy sharing the stimulus, used to reach saturation quickly.
  branch_redirect_ctrl #(.FLUSH_CYCLES(FL), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .br_valid_i(br_valid), .br_ready_o(s_ready),
    .br_type_i(br_type), .pc_plus4_i(pc_plus4), .imm_i(imm), .jaddr_i(jaddr),
    .rs_data_i(rs_data), .rt_data_i(rt_data), .redirect_valid_o(s_rv),
    .redirect_pc_o(s_pc), .redirect_ack_i(redirect_ack), .flush_o(s_flush),
    .link_we_o(s_lwe), .link_data_o(s_ldata), .align_err_o(s_aerr),
    .taken_cnt_o(s_cnt));

  function automatic bit ref_taken(input logic [2:0] t, input logic [31:0] rs, input logic [31:0] rt);
    case (t)
      3'd1: return rs == rt;
      3'd2: return rs != rt;
      3'd3, 3'd4, 3'd5: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [2:0] t, input logic [31:0] pc,
                                             input logic [15:0] im, input logic [25:0] ja,
                                             input logic [31:0] rs);
    int si;
    si = int'($signed(im));
    case (t)
      3'd1, 3'd2: return pc + 32'(si * 4);
      3'd3, 3'd4: return (pc & 32'hF000_0000) | (32'(ja) * 32'd4);
      3'd5: return rs & 32'hFFFF_FFFC;
      default: return 32'd0;
    endcase
  endfunction

  // One transaction; starts and ends #1 after a rising edge with the DUT idle.
  task automatic run_req(input logic [2:0] t, input logic [31:0] pc, input logic [15:0] im,
                         input logic [25:0] ja, input logic [31:0] rs, input logic [31:0] rt,
                         input int delay, input int abort_at);
    bit          tk;
    logic [31:0] tgt;
    tk  = ref_taken(t, rs, rt);
    tgt = ref_target(t, pc, im, ja, rs);
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL ready_before got %b want 1", br_ready); end
    br_valid = 1'b1; br_type = t; pc_plus4 = pc; imm = im; jaddr = ja; rs_data = rs; rt_data = rt;
    redirect_ack = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    br_valid = 1'b0; pc_plus4 = $urandom; rs_data = $urandom; rt_data = $urandom; imm = 16'($urandom);
    redirect_ack = 1'($urandom_range(0, 1));
    checks++; if (br_ready !== 1'b0 || redirect_valid !== 1'b0 || flush !== 1'b0) begin
      errors++; $display("FAIL eval_ctl got rdy=%b rv=%b fl=%b want 0/0/0", br_ready, redirect_valid, flush); end
    checks++; if (link_we !== (t == 3'd4)) begin errors++; $display("FAIL link_we got %b want %b", link_we, t == 3'd4); end
    if (t == 3'd4) begin
      checks++; if (link_data !== pc) begin errors++; $display("FAIL link_data got %h want %h", link_data, pc); end
    end
    checks++; if (align_err !== (t == 3'd5 && rs[1:0] != 2'b00)) begin
      errors++; $display("FAIL align_err got %b want %b", align_err, t == 3'd5 && rs[1:0] != 2'b00); end
    @(posedge clk); #1;
    if (!tk) begin
      redirect_ack = 1'b0;
      checks++; if (br_ready !== 1'b1 || redirect_valid !== 1'b0 || flush !== 1'b0 || taken_cnt !== 16'(exp_cnt)) begin
        errors++; $display("FAIL not_taken got rdy=%b rv=%b fl=%b cnt=%0d want 1/0/0/%0d",
                           br_ready, redirect_valid, flush, taken_cnt, exp_cnt); end
      return;
    end
    for (int k = 0; k <= delay; k++) begin
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== tgt || flush !== 1'b0 || br_ready !== 1'b0 || link_we !== 1'b0) begin
        errors++; $display("FAIL redirect got rv=%b pc=%h fl=%b rdy=%b want 1/%h/0/0", redirect_valid, redirect_pc, flush, br_ready, tgt); end
      redirect_ack = (k == delay);
      br_valid = 1'($urandom_range(0, 1)); br_type = 3'($urandom); pc_plus4 = $urandom;
      @(posedge clk); #1;
    end
    redirect_ack = 1'b0; br_valid = 1'b0;
    exp_cnt  = (exp_cnt == 65535) ? 65535 : exp_cnt + 1;
    exp_cnt4 = (exp_cnt4 == 15) ? 15 : exp_cnt4 + 1;
    for (int f = 0; f < FL; f++) begin
      if (f == abort_at) begin
        reset = 1'b0; #1;
        exp_cnt = 0; exp_cnt4 = 0;
        checks++; if (br_ready !== 1'b1 || flush !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'd0 ||
                      taken_cnt !== 16'd0 || link_we !== 1'b0 || align_err !== 1'b0) begin
          errors++; $display("FAIL async_reset got rdy=%b fl=%b rv=%b pc=%h cnt=%0d want 1/0/0/0/0",
                             br_ready, flush, redirect_valid, redirect_pc, taken_cnt); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        return;
      end
      redirect_ack = 1'($urandom_range(0, 1));
      checks++; if (flush !== 1'b1 || redirect_valid !== 1'b0 || redirect_pc !== 32'd0 || br_ready !== 1'b0) begin
        errors++; $display("FAIL flush got fl=%b rv=%b pc=%h rdy=%b want 1/0/0/0", flush, redirect_valid, redirect_pc, br_ready); end
      checks++; if (taken_cnt !== 16'(exp_cnt) || s_cnt !== 4'(exp_cnt4)) begin
        errors++; $display("FAIL taken_cnt got %0d/%0d want %0d/%0d", taken_cnt, s_cnt, exp_cnt, exp_cnt4); end
      @(posedge clk); #1;
    end
    redirect_ack = 1'b0;
    checks++; if (br_ready !== 1'b1 || flush !== 1'b0) begin
      errors++; $display("FAIL flush_end got rdy=%b fl=%b want 1/0", br_ready, flush); end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (br_ready !== 1'b1 || redirect_valid !== 1'b0 || flush !== 1'b0 || taken_cnt !== 16'd0 ||
                  redirect_pc !== 32'd0 || link_data !== 32'd0) begin
      errors++; $display("FAIL reset_state got rdy=%b rv=%b fl=%b cnt=%0d", br_ready, redirect_valid, flush, taken_cnt); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_beq();
    run_req(3'd1, 32'h0040_0010, 16'hFFFC, 26'd0, 32'h5, 32'h5, 0, -1);
    checks++; if (taken_cnt !== 16'd1) begin errors++; $display("FAIL beq_cnt got %0d want 1", taken_cnt); end
  endtask

  task automatic test_bne();
    run_req(3'd2, 32'h0040_0010, 16'h0008, 26'd0, 32'h7, 32'h7, 0, -1);
  endtask

  task automatic test_jal();
    run_req(3'd4, 32'h9000_0004, 16'h0, 26'h010_0000, 32'h0, 32'h0, 1, -1);
  endtask

  task automatic test_jr_delayed();
    run_req(3'd5, 32'h0000_1000, 16'h0, 26'h0, 32'h0040_0023, 32'h0, 3, -1);
  endtask

  task automatic test_reset_mid_flush();
    run_req(3'd3, 32'h1234_5678, 16'h0, 26'h2AA_AAAA, 32'h0, 32'h0, 0, 1);
    run_req(3'd1, 32'h0000_0100, 16'h0010, 26'h0, 32'h9, 32'h9, 0, -1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++)
      run_req(3'd3, $urandom, 16'($urandom), 26'($urandom), $urandom, $urandom, 0, -1);
    checks++; if (s_cnt !== 4'hF) begin errors++; $display("FAIL sat_cnt got %h want f", s_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [31:0] rs;
      rs = $urandom;
      run_req(3'($urandom), $urandom, 16'($urandom), 26'($urandom), rs,
              ($urandom_range(0, 1) == 1) ? rs : $urandom, int'($urandom_range(0, 3)), -1);
    end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_bne();
    test_jal();
    test_jr_delayed();
    test_reset_mid_flush();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
